// File: rtl/ram_pkg.sv
// Shared types and constants for the self-clearing simple dual-port RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result pipeline: READ_LATENCY stages of data/valid, last stage drives q.
module ram_rd_pipe #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid
);

  logic [READ_LATENCY-1:0] valid_q;
  logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];

  // Data stages load only behind a valid, so the last stage holds the previous result.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign q       = data_q[READ_LATENCY-1];
  assign q_valid = valid_q[READ_LATENCY-1];

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM with byte enables, selectable read-during-write and a
// post-reset clear sequence that zeroes every entry before accepting requests.
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned BYTE_W       = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = RDW_OLD
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [DATA_WIDTH-1:0]            data,
  input  logic [(DATA_WIDTH/BYTE_W)-1:0]   be,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  output logic [DATA_WIDTH-1:0]            q,
  output logic                             q_valid,
  output logic                             init_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / BYTE_W;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gen_bad_latency
    $error("ram_sdp_clr: READ_LATENCY must be 1 or 2");
  end
  if (BYTE_W == 0 || (DATA_WIDTH % BYTE_W) != 0) begin : gen_bad_width
    $error("ram_sdp_clr: DATA_WIDTH must be a multiple of BYTE_W");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : gen_bad_rdw
    $error("ram_sdp_clr: RDW_MODE must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
      if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
        state_q <= READY;
      end
    end
  end

  assign init_busy = (state_q == CLEAR);
  assign wr_en     = we && (state_q == READY);
  assign rd_en     = re && (state_q == READY);

  always_comb begin
    wr_merged = mem[write_addr];
    for (int i = 0; i < int'(NB); i++) begin
      if (be[i]) begin
        wr_merged[i*BYTE_W +: BYTE_W] = data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Contents are never reset; the clear sequence is the only source of zeroes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_ptr_q] <= '0;
      end else if (wr_en) begin
        mem[write_addr] <= wr_merged;
      end
    end
  end

  // The word is captured in the request cycle, so later writes cannot disturb it.
  always_comb begin
    rd_word = mem[read_addr];
    if (RDW_MODE == RDW_NEW && wr_en && (read_addr == write_addr)) begin
      rd_word = wr_merged;
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clock   (clock),
    .reset   (reset),
    .in_valid(rd_en),
    .in_data (rd_word),
    .q       (q),
    .q_valid (q_valid)
  );

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: two instances (8-bit/latency 1/old-data and
// 32-bit/latency 2/new-data) driven in lockstep and checked against a word-level model.
module tb_ram_sdp_clr;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [5:0]  write_addr = '0;
  logic [5:0]  read_addr = '0;
  logic [31:0] data = '0;
  logic [3:0]  be = '0;

  logic [7:0]  q0;
  logic        q_valid0, busy0;
  logic [31:0] q1;
  logic        q_valid1, busy1;

  always #5 clock = ~clock;

  ram_sdp_clr #(
    .DATA_WIDTH(8), .ADDR_WIDTH(6), .BYTE_W(8), .READ_LATENCY(1), .RDW_MODE(0)
  ) u_dut0 (
    .clock(clock), .reset(reset), .we(we), .write_addr(write_addr), .data(data[7:0]),
    .be(be[0:0]), .re(re), .read_addr(read_addr), .q(q0), .q_valid(q_valid0),
    .init_busy(busy0)
  );

  ram_sdp_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_W(8), .READ_LATENCY(2), .RDW_MODE(1)
  ) u_dut1 (
    .clock(clock), .reset(reset), .we(we), .write_addr(write_addr), .data(data),
    .be(be), .re(re), .read_addr(read_addr), .q(q1), .q_valid(q_valid1),
    .init_busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 1'b0;
  int clr_cnt = 0;

  logic [7:0]  mem0 [64];
  logic [31:0] mem1 [64];

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;
  exp_t exp0[$];
  exp_t exp1[$];

  logic [31:0] last0 = '0, last1 = '0;
  logic [31:0] got0 = '0, got1 = '0;
  int pulses0 = 0, pulses1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: 64 clear cycles after reset, then reads return the word as of the
  // request edge (old data for instance 0, post-write data for instance 1).
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      model_on = 1'b1;
      clr_cnt  = 0;
      exp0.delete();
      exp1.delete();
      last0 = '0;
      last1 = '0;
    end else if (model_on) begin
      if (clr_cnt < 64) begin
        clr_cnt++;
        if (clr_cnt == 64) begin
          foreach (mem0[a]) mem0[a] = '0;
          foreach (mem1[a]) mem1[a] = '0;
        end
      end else begin
        if (re) exp0.push_back('{cyc, {24'b0, mem0[read_addr]}});
        if (we) begin
          if (be[0]) mem0[write_addr] = data[7:0];
          for (int l = 0; l < 4; l++) begin
            if (be[l]) mem1[write_addr][l*8 +: 8] = data[l*8 +: 8];
          end
        end
        if (re) exp1.push_back('{cyc + 1, mem1[read_addr]});
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("busy0", {31'b0, busy0}, {31'b0, clr_cnt < 64});
      chk("busy1", {31'b0, busy1}, {31'b0, clr_cnt < 64});
      if (exp0.size() > 0 && exp0[0].due == cyc) begin
        chk("q_valid0", {31'b0, q_valid0}, 32'd1);
        chk("q0", {24'b0, q0}, exp0[0].val);
        last0 = exp0[0].val;
        void'(exp0.pop_front());
      end else begin
        chk("q_valid0_idle", {31'b0, q_valid0}, 32'd0);
        chk("q0_hold", {24'b0, q0}, last0);
      end
      if (exp1.size() > 0 && exp1[0].due == cyc) begin
        chk("q_valid1", {31'b0, q_valid1}, 32'd1);
        chk("q1", q1, exp1[0].val);
        last1 = exp1[0].val;
        void'(exp1.pop_front());
      end else begin
        chk("q_valid1_idle", {31'b0, q_valid1}, 32'd0);
        chk("q1_hold", q1, last1);
      end
      if (q_valid0) begin pulses0++; got0 = {24'b0, q0}; end
      if (q_valid1) begin pulses1++; got1 = q1; end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; be = '0;
  endtask

  task automatic op(input bit w, input logic [5:0] wa, input logic [31:0] d,
                    input logic [3:0] b, input bit r, input logic [5:0] ra);
    we = w; write_addr = wa; data = d; be = b; re = r; read_addr = ra;
    tick();
    idle();
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic read_chk(input string name, input logic [5:0] a,
                          input logic [31:0] e0, input logic [31:0] e1);
    int p0, p1;
    p0 = pulses0; p1 = pulses1;
    op(1'b0, '0, '0, '0, 1'b1, a);
    drain();
    chk({name, "_n0"}, pulses0 - p0, 32'd1);
    chk({name, "_n1"}, pulses1 - p1, 32'd1);
    chk({name, "_q0"}, got0, e0);
    chk({name, "_q1"}, got1, e1);
  endtask

  // Counts negedges with init_busy high, bounded so a stuck FSM still ends.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (!busy0) break;
      n++;
    end
    idle();
    tick();
  endtask

  initial begin
    int n, p0, p1;
    logic [5:0] v0, v1;
    logic [31:0] lq1 [6];

    idle();
    repeat (3) tick();
    reset = 1'b0;
    count_busy(n);
    chk("clear_len", n, 32'd64);

    p0 = pulses0; p1 = pulses1;
    for (int a = 0; a < 64; a++) begin
      re = 1'b1; read_addr = 6'(a);
      tick();
    end
    idle();
    drain();
    chk("clear_reads0", pulses0 - p0, 32'd64);
    chk("clear_reads1", pulses1 - p1, 32'd64);

    op(1'b1, 6'd5, 32'hAABBCCDD, 4'b1111, 1'b0, '0);
    op(1'b1, 6'd5, 32'h11223344, 4'b0101, 1'b0, '0);
    op(1'b1, 6'd5, 32'hDEADBEEF, 4'b0000, 1'b0, '0);
    chk("model_be", mem1[5], 32'hAA22CC44);
    read_chk("be", 6'd5, 32'h44, 32'hAA22CC44);

    op(1'b1, 6'd3, 32'h0000FFFF, 4'b1111, 1'b0, '0);
    p0 = pulses0; p1 = pulses1;
    op(1'b1, 6'd3, 32'h12345678, 4'b1111, 1'b1, 6'd3);
    drain();
    chk("rdw_n1", pulses1 - p1, 32'd1);
    chk("rdw_old", got0, 32'hFF);
    chk("rdw_new", got1, 32'h12345678);

    for (int a = 1; a <= 3; a++) op(1'b1, 6'(a), 32'(a), 4'b1111, 1'b0, '0);
    v0 = '0; v1 = '0;
    fork
      begin
        for (int a = 1; a <= 3; a++) begin
          re = 1'b1; read_addr = 6'(a);
          tick();
        end
        idle();
      end
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clock);
          v0[k] = q_valid0; v1[k] = q_valid1; lq1[k] = q1;
        end
      end
    join
    tick();
    chk("lat1_valid", {26'b0, v0}, 32'b001110);
    chk("lat2_valid", {26'b0, v1}, 32'b011100);
    chk("lat2_q_a", lq1[2], 32'h01);
    chk("lat2_q_b", lq1[3], 32'h02);
    chk("lat2_q_c", lq1[4], 32'h03);

    reset = 1'b1; tick(); reset = 1'b0;
    repeat (30) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    p0 = pulses0; p1 = pulses1;
    re = 1'b1; read_addr = 6'd7;
    count_busy(n);
    chk("reclear_len", n, 32'd64);
    chk("reclear_no_q0", pulses0 - p0, 32'd0);
    chk("reclear_no_q1", pulses1 - p1, 32'd0);

    op(1'b1, 6'd63, 32'hFF, 4'b1111, 1'b0, '0);
    op(1'b1, 6'd0, 32'h01, 4'b1111, 1'b0, '0);
    read_chk("top_addr", 6'd63, 32'hFF, 32'hFF);
    read_chk("bot_addr", 6'd0, 32'h01, 32'h01);

    for (int k = 0; k < 3000; k++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      write_addr = 6'($urandom_range(0, 63));
      read_addr = ($urandom_range(0, 3) == 0) ? write_addr : 6'($urandom_range(0, 63));
      data = $urandom;
      be = 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_sdp_clr.md
RAM_SDP_CLR -- requirements
Module: ram_sdp_clr

Interface
REQ-001 Parameter: DATA_WIDTH, 8, word width in bits; SHALL be a multiple of BYTE_W.
REQ-002 Parameter: ADDR_WIDTH, 6, address width; depth SHALL be 2**ADDR_WIDTH.
REQ-003 Parameter: BYTE_W, 8, byte-lane width; NB = DATA_WIDTH/BYTE_W lanes.
REQ-004 Parameter: READ_LATENCY, 1, cycles from read request to q; legal values 1 or 2 only.
REQ-005 Parameter: RDW_MODE, 0, same-address read-during-write result; 0 = old data, 1 = new (merged) data.
REQ-006 Port: clock  input  1  single clock; all logic on its rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Port: we  input  1  write request.
REQ-009 Port: write_addr  input  ADDR_WIDTH  write address.
REQ-010 Port: data  input  DATA_WIDTH  write data.
REQ-011 Port: be  input  NB  byte enables; bit i gates lane i.
REQ-012 Port: re  input  1  read request.
REQ-013 Port: read_addr  input  ADDR_WIDTH  read address.
REQ-014 Port: q  output  DATA_WIDTH  registered read data.
REQ-015 Port: q_valid  output  1  one-cycle pulse marking q as holding a fresh read result.
REQ-016 Port: init_busy  output  1  high while the array is being cleared; requests are ignored.

Function
REQ-017 Clear FSM SHALL have states CLEAR and READY; reset forces CLEAR with clear pointer = 0.
REQ-018 In CLEAR, one entry per cycle SHALL be written with all zeros at the clear pointer, and the pointer SHALL then increment.
REQ-019 After the entry at address 2**ADDR_WIDTH-1 is written, the FSM SHALL move to READY on the next edge; the clear takes exactly 2**ADDR_WIDTH cycles after reset deasserts.
REQ-020 init_busy SHALL be 1 in CLEAR and 0 in READY.
REQ-021 In CLEAR, we and re SHALL be ignored: no user write, and no q_valid pulse.
REQ-022 In READY, a write with we=1 SHALL update only the lanes with be[i]=1; lanes with be[i]=0 keep their content. we=1 with be=0 SHALL be a no-op.
REQ-023 In READY, re=1 in cycle N SHALL present the word at read_addr on q and pulse q_valid=1 in cycle N+READ_LATENCY.
REQ-024 Back-to-back reads SHALL be accepted every cycle with full throughput, and results SHALL return in request order.
REQ-025 q SHALL hold its last value when q_valid=0.
REQ-026 Same-cycle we=1, re=1 with read_addr == write_addr: with RDW_MODE=0, q SHALL return the pre-write word; with RDW_MODE=1, q SHALL return the post-write word with byte enables applied.
REQ-027 With READY_LATENCY=2, array data SHALL be sampled in the request cycle; a write to that address in cycle N+1 SHALL NOT alter the returned word.
REQ-028 Different-address simultaneous read and write SHALL each complete independently.
REQ-029 Addresses SHALL span the full 2**ADDR_WIDTH range with no out-of-range condition.

Reset
REQ-030 While reset=1: q=0, q_valid=0, init_busy=1, read pipeline valid bits cleared, FSM=CLEAR, pointer=0.
REQ-031 Reset asserted mid-clear or mid-read SHALL drop in-flight reads (no q_valid) and SHALL restart the clear from address 0.
REQ-032 Memory contents SHALL NOT be reset directly; zeroing is done only by the clear sequence.

Structure
REQ-033 A shared package ram_pkg SHALL hold the clear-FSM state enum and the RDW_MODE encoding constants (RDW_OLD=0, RDW_NEW=1).
REQ-034 One sub-module, ram_rd_pipe, SHALL implement the READ_LATENCY-deep data/valid pipeline. The array, write merge and clear FSM SHALL stay in ram_sdp_clr.
REQ-035 An illegal READ_LATENCY or DATA_WIDTH % BYTE_W != 0 SHALL be an elaboration-time error.

Verification
REQ-036 Clear check (defaults): deassert reset; init_busy=1 for exactly 64 cycles, then 0. Reading all 64 addresses returns 0x00, each with a q_valid pulse.
REQ-037 Byte enables (DATA_WIDTH=32): write 0xAABBCCDD with be=1111 to addr 5, then 0x11223344 with be=0101. Read addr 5 returns 0xAA22CC44.
REQ-038 RDW (DATA_WIDTH=32, addr 3 holds 0x0000FFFF): same cycle write 0x12345678 with be=1111 and read addr 3. RDW_MODE=0 returns 0x0000FFFF; RDW_MODE=1 returns 0x12345678.
REQ-039 Latency: READ_LATENCY=2, read addrs 1,2,3 in consecutive cycles after writing 0x01,0x02,0x03. q_valid is high in cycles N+2..N+4 with q = 0x01, 0x02, 0x03.
REQ-040 Reset mid-clear: assert reset at clear cycle 30 for 1 cycle. init_busy stays high for 64 further cycles; a read issued during the clear produces no q_valid.
REQ-041 Boundary: write 0xFF to addr 63 and 0x01 to addr 0. Reads return 0xFF and 0x01 respectively, with no aliasing between the two.
